bcd_sub_serial: RTL and testbench

BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_sub.sv | 26 ++
 rtl/bcd_sub_serial.sv | 128 ++++++++++++
 tb/tb_bcd_sub_serial.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the serial BCD adder and subtractor.
//   bcd_state_e   : sequencer states (IDLE, RUN, DONE)
//   BCD_DIGIT_W   : bits per packed BCD digit
//   BCD_RADIX     : decimal radix, used for the borrow correction
//   BCD_MAX_DIGIT : largest legal digit value
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } bcd_state_e;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_RADIX     = 10;
  localparam int unsigned BCD_MAX_DIGIT = 9;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor, purely combinational.
//   a_d  : minuend digit
//   b_d  : subtrahend digit
//   bin  : borrow in
//   d    : result digit, a_d - b_d - bin, corrected by +10 when negative
//   bout : borrow out, set when a_d - b_d - bin is negative
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a_d,
  input  logic [BCD_DIGIT_W-1:0] b_d,
  input  logic                   bin,
  output logic [BCD_DIGIT_W-1:0] d,
  output logic                   bout
);

  // One extra bit holds the sign of the raw difference (range -16..15).
  logic [BCD_DIGIT_W:0] t;

  always_comb begin
    t    = {1'b0, a_d} - {1'b0, b_d} - {{BCD_DIGIT_W{1'b0}}, bin};
    bout = t[BCD_DIGIT_W];
    d    = bout ? t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_RADIX) : t[BCD_DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: diff = a - b - borrow_in, one digit per cycle,
// least significant digit first.
//   clk, rst_n  : clock and asynchronous active-low reset
//   start       : request, accepted only when idle; a, b, borrow_in captured then
//   a, b        : packed BCD operands, digit 0 in [3:0]
//   borrow_in   : initial borrow into digit 0
//   busy        : high while an operation is in progress (RUN and DONE)
//   done        : one-cycle completion pulse
//   diff        : packed BCD result, held until the next accepted start
//   borrow_out  : final borrow out of the most significant digit
//   invalid     : an operand digit exceeded 9 (only when BCD_SUB_CHECK_EN is defined,
//                 otherwise tied low)
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                        borrow_in,
  output logic                        busy,
  output logic                        done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] diff,
  output logic                        borrow_out,
  output logic                        invalid
);

  localparam int unsigned W    = BCD_DIGIT_W * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd_state_e            state_q, state_d;
  logic [IdxW-1:0]       idx_q;
  logic [W-1:0]          a_q, b_q, diff_q;
  logic                  borrow_q, borrow_out_q;
  logic                  accept, last_digit;
  logic [BCD_DIGIT_W-1:0] dig_d;
  logic                  dig_bout;

  assign accept     = (state_q == IDLE) && start;
  assign last_digit = (idx_q == IdxW'(DIGITS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands shift right so the digit in flight is always at [3:0].
  bcd_digit_sub u_digit (
    .a_d  (a_q[BCD_DIGIT_W-1:0]),
    .b_d  (b_q[BCD_DIGIT_W-1:0]),
    .bin  (borrow_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q      <= a;
        b_q      <= b;
        borrow_q <= borrow_in;
        idx_q    <= '0;
      end else if (state_q == RUN) begin
        a_q      <= a_q >> BCD_DIGIT_W;
        b_q      <= b_q >> BCD_DIGIT_W;
        borrow_q <= dig_bout;
        // Result digits enter at the top and reach their final place after DIGITS shifts.
        diff_q   <= (diff_q >> BCD_DIGIT_W) | (W'(dig_d) << (W - BCD_DIGIT_W));
        if (last_digit) begin
          idx_q        <= '0;
          borrow_out_q <= dig_bout;
        end else begin
          idx_q <= idx_q + IdxW'(1);
        end
      end
    end
  end

`ifdef BCD_SUB_CHECK_EN
  logic operand_bad;
  logic invalid_q;

  always_comb begin
    operand_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (a[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT) ||
          b[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT)) begin
        operand_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invalid_q <= 1'b0;
    end else if (accept) begin
      invalid_q <= operand_bad;
    end
  end

  assign invalid = invalid_q;
`else
  assign invalid = 1'b0;
`endif

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Scoreboard bench for bcd_sub_serial (DIGITS=4). Stimulus pushes the hand-computed result
// of every accepted operation; the monitor pops and compares on each done pulse.
module tb_bcd_sub_serial;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

`ifdef BCD_SUB_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic         busy, done, borrow_out, invalid;
  logic [W-1:0] diff;

  typedef struct {
    logic [W-1:0] diff;
    logic         bo;
    logic         inv;
    bit           chk_diff;
    int           accept_cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .invalid    (invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: done is sampled by the edge DIGITS+1 after the accept edge.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_latency"}, 32'(cyc + 1 - e.accept_cyc), 32'(DIGITS + 1));
        if (e.chk_diff) check({e.name, "_diff"}, 32'(diff), 32'(e.diff));
        if (e.chk_diff) check({e.name, "_borrow"}, 32'(borrow_out), 32'(e.bo));
        check({e.name, "_invalid"}, 32'(invalid), 32'(e.inv));
        check({e.name, "_busy"}, 32'(busy), 32'd1);
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    if (busy) check({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  // Drive one operation from a negedge; returns after the DUT is idle again.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vbi, input logic [W-1:0] ed, input logic eb,
                        input logic einv, input bit chk);
    exp_t e;
    a = va; b = vb; borrow_in = vbi; start = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_accept_busy"}, 32'(busy), 32'd1);
    e.diff = ed; e.bo = eb; e.inv = einv; e.chk_diff = chk; e.accept_cyc = cyc; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_idle(name);
    // Result must hold while idle.
    repeat (3) @(negedge clk);
    if (chk) check({name, "_hold_diff"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_invalid", 32'(invalid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("basic",    16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0, 1'b1);
    run_op("wrap",     16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b1);
    run_op("bin",      16'h5000, 16'h0001, 1'b1, 16'h4998, 1'b0, 1'b0, 1'b1);
    run_op("equal",    16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("zero_bin", 16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1);
    run_op("mixed",    16'h4321, 16'h1234, 1'b0, 16'h3087, 1'b0, 1'b0, 1'b1);
    run_op("chain",    16'h0100, 16'h0099, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1);

    // Start re-pulsed mid-run with new operands must be ignored.
    begin
      exp_t e;
      a = 16'h1234; b = 16'h0567; borrow_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      e.diff = 16'h0667; e.bo = 1'b0; e.inv = 1'b0; e.chk_diff = 1'b1; e.accept_cyc = cyc;
      e.name = "repulse";
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'h9999; b = 16'h0001; borrow_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("repulse_busy", 32'(busy), 32'd1);
      wait_idle("repulse");
      repeat (3) @(negedge clk);
      check("repulse_single", 32'(sb.size()), 32'd0);
    end

    // Asynchronous reset in the middle of RUN.
    a = 16'h1234; b = 16'h0567; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 16'h4321, 16'h1234, 1'b0, 16'h3087, 1'b0, 1'b0, 1'b1);

    run_op("bad_digit", 16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, CheckEn, 1'b0);
    run_op("clear_inv", 16'h0010, 16'h0001, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
